ex_mem_stage: RTL
=================

# ex_mem_stage

Parametrised execute/memory stage for the pipelined CPU. Sits between the ID/EX buffer and the MEM/WB stage and contains the ALU, a synchronous-read data memory, an optional multi-cycle multiplier, and a registered EX/MEM output buffer. Data width, register-tag width and memory depth are parameters. Valid/ready handshakes and a flush input support stalls and branch squashes.

## Interface
- DATA_W, 32, datapath width; also the width of rs, rt, SE and all results.
- RD_W, 6, destination-register tag width.
- MEM_DEPTH, 256, data-memory depth in words; must be a power of 2; address = rs[log2(MEM_DEPTH)-1:0].
- MUL_LAT, 3, multiply latency in cycles, ≥1; only used with EX_MUL_EN.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  squash the op in flight and the output buffer.
- in_valid  in  1  ID/EX holds a valid op.
- in_ready  out  1  stage accepts an op this cycle.
- in_aluop  in  3  ALU opcode.
- in_ctrl  in  9  control bits: [0] RegWrt, [1] MemtoReg, [2] PCtoReg, [3] MemRead, [4] MemWrt, [5] BrNeg, [6] BrZ, [7] Jump, [8] JumpMem.
- in_rs, in_rt, in_se  in  DATA_W  operand A, operand B / store data, sign-extended branch offset.
- in_rd  in  RD_W  destination tag.
- out_valid  out  1  EX/MEM buffer holds a valid result.
- out_ready  in  1  downstream consumes the buffer.
- out_alu, out_mem, out_branch  out  DATA_W  ALU result, memory read data, registered in_se.
- out_rd  out  RD_W; out_ctrl  out  7  = in_ctrl bits {8,7,6,5,2,1,0}, in that order MSB to LSB.
- out_zero, out_neg  out  1  flags of out_alu.

## Operation
- Opcodes: 000 A+B, 001 A+1, 010 −A, 011 A−B, 100 A, 101 A&B, 110 A|B, 111 A×B (low DATA_W bits). All arithmetic is modulo 2^DATA_W. zero = (result == 0); neg = result[DATA_W−1].
- FSM states: IDLE, MEMRD, MUL.
- Accept = in_valid && in_ready. in_ready = !flush && state==IDLE && (!out_valid || out_ready).
- At accept, in IDLE:
  - If MemWrt: mem[addr] ← rt at that edge.
  - If MemRead: a read is issued at the same edge and the FSM goes to MEMRD. A combined MemRead+MemWrt to the same address returns the old data (read-before-write).
  - Else if op 111 with EX_MUL_EN: FSM goes to MUL; the counter loads MUL_LAT−1.
  - Else: the output buffer loads at the accept edge.
- MEMRD: the output buffer loads (out_mem = read data), FSM → IDLE.
- MUL: the counter decrements each cycle. At 0 the output buffer loads the product and FSM → IDLE.
- When no read occurred, out_mem = 0.
- Output buffer: out_valid clears when out_ready && out_valid and nothing new loads. It stays set when a load and a consume happen on the same edge. Contents are held while out_valid && !out_ready.
- flush (priority over everything except reset):
  - Next edge: out_valid ← 0, FSM → IDLE, counter cleared.
  - No accept occurs during flush.
  - Memory writes committed on earlier edges are not undone.
- Reset (rst_n = 0 at edge): state IDLE, counter 0, out_valid 0, and every out_* data/flag/ctrl field 0. in_ready is 0 while rst_n = 0. Memory contents are not reset. Reset mid-MEMRD or mid-MUL discards the op.

## Timing
- ALU ops: out_valid rises 1 cycle after accept; throughput 1 op/cycle while out_ready = 1.
- Loads: 2 cycles accept→out_valid; in_ready = 0 during MEMRD.
- Multiply: MUL_LAT cycles accept→out_valid; in_ready = 0 during MUL.
- Stores: write visible to a read issued on any later edge.
- Backpressure: with out_valid && !out_ready, in_ready = 0. An FSM in MEMRD or MUL waits in its final step until the buffer is free; the result is not dropped.

## Configuration
- EX_MUL_EN defined: opcode 111 runs the MUL_LAT-cycle multiplier.
- EX_MUL_EN undefined: no multiplier logic and the MUL state is unreachable. Opcode 111 completes in 1 cycle with result 0, zero = 1, neg = 0.

## Test plan
- Reset: hold rst_n = 0 for 2 cycles with in_valid = 1 -> in_ready = 0, out_valid = 0, all outputs 0; no memory write occurs.
- Back-to-back ALU: SUB 5−7 then ADD 3+4, with out_ready = 1 -> consecutive cycles show out_alu 0xFFFFFFFE (neg = 1), then 7 (zero = 0).
- Store/load: MemWrt rs = 4, rt = 0xDEADBEEF, then MemRead rs = 4 -> out_mem = 0xDEADBEEF 2 cycles after the load accept; in_ready = 0 for 1 cycle.
- Backpressure: out_ready = 0 for 3 cycles with in_valid = 1 -> out_* held stable, in_ready = 0; the next op is accepted the cycle after out_ready rises.
- Flush: flush during MEMRD with out_valid = 1 -> next cycle out_valid = 0, FSM IDLE, in_ready = 1.
- EX_MUL_EN, MUL_LAT = 3: 6×7 -> out_alu = 42 exactly 3 cycles after accept. Without the macro: out_alu = 0, zero = 1 after 1 cycle.

Source files
------------

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: execute/memory pipeline stage.
// Contains the ALU, a synchronous-read data memory, an optional multi-cycle
// multiplier and the registered EX/MEM output buffer, with valid/ready
// handshakes on both sides and a flush input for branch squashes.
// Optional feature macro: EX_MUL_EN. When it is defined, opcode 111 runs the
// MUL_LAT-cycle multiplier. When it is undefined, opcode 111 completes in one
// cycle with result 0.
module ex_mem_stage #(
  parameter int DATA_W    = 32,
  parameter int RD_W      = 6,
  parameter int MEM_DEPTH = 256,
  parameter int MUL_LAT   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_aluop,
  input  logic [8:0]        in_ctrl,
  input  logic [DATA_W-1:0] in_rs,
  input  logic [DATA_W-1:0] in_rt,
  input  logic [DATA_W-1:0] in_se,
  input  logic [RD_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_alu,
  output logic [DATA_W-1:0] out_mem,
  output logic [DATA_W-1:0] out_branch,
  output logic [RD_W-1:0]   out_rd,
  output logic [6:0]        out_ctrl,
  output logic              out_zero,
  output logic              out_neg
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  typedef enum logic [1:0] {IDLE, MEMRD, MUL} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] mem [MEM_DEPTH];

  logic [AW-1:0]     addr;
  logic              bufFree;
  logic              accept;
  logic              goMul;
  logic [DATA_W-1:0] aluRes;
  logic [6:0]        ctrlSel;

  // Ops waiting in MEMRD or MUL keep their fields here until the buffer loads.
  logic [DATA_W-1:0] pAlu;
  logic [DATA_W-1:0] pBranch;
  logic [DATA_W-1:0] pRdData;
  logic [RD_W-1:0]   pRd;
  logic [6:0]        pCtrl;

  // Values presented to the output buffer when it loads.
  logic              loadEn;
  logic [DATA_W-1:0] ldAlu;
  logic [DATA_W-1:0] ldMem;
  logic [DATA_W-1:0] ldBranch;
  logic [RD_W-1:0]   ldRd;
  logic [6:0]        ldCtrl;

  assign addr     = in_rs[AW-1:0];
  assign bufFree  = !out_valid || out_ready;
  assign in_ready = rst_n && !flush && (state == IDLE) && bufFree;
  assign accept   = in_valid && in_ready;
  assign ctrlSel  = {in_ctrl[8], in_ctrl[7], in_ctrl[6], in_ctrl[5],
                     in_ctrl[2], in_ctrl[1], in_ctrl[0]};

`ifdef EX_MUL_EN
  // A one-cycle multiply behaves exactly like a plain ALU op.
  assign goMul = (in_aluop == 3'b111) && (MUL_LAT > 1);
`else
  assign goMul = 1'b0;
`endif

  // ALU result for the op currently offered by ID/EX.
  always_comb begin
    aluRes = '0;
    case (in_aluop)
      3'b000: aluRes = in_rs + in_rt;
      3'b001: aluRes = in_rs + DATA_W'(1);
      3'b010: aluRes = '0 - in_rs;
      3'b011: aluRes = in_rs - in_rt;
      3'b100: aluRes = in_rs;
      3'b101: aluRes = in_rs & in_rt;
      3'b110: aluRes = in_rs | in_rt;
`ifdef EX_MUL_EN
      3'b111: aluRes = in_rs * in_rt;
`else
      3'b111: aluRes = '0;
`endif
      default: aluRes = '0;
    endcase
  end

  // Select what the output buffer loads this cycle, and whether it loads.
  always_comb begin
    loadEn   = 1'b0;
    ldAlu    = pAlu;
    ldMem    = '0;
    ldBranch = pBranch;
    ldRd     = pRd;
    ldCtrl   = pCtrl;
    case (state)
      IDLE: begin
        if (accept && !in_ctrl[3] && !goMul) begin
          loadEn   = 1'b1;
          ldAlu    = aluRes;
          ldBranch = in_se;
          ldRd     = in_rd;
          ldCtrl   = ctrlSel;
        end
      end
      MEMRD: begin
        loadEn = bufFree;
        ldMem  = pRdData;
      end
      MUL: begin
        loadEn = bufFree && (cnt <= CW'(1));
      end
      default: loadEn = 1'b0;
    endcase
    if (flush) loadEn = 1'b0;
  end

  // Data memory write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (accept && in_ctrl[4]) mem[addr] <= in_rt;
  end

  // FSM, pending-op registers and the EX/MEM output buffer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      pAlu       <= '0;
      pBranch    <= '0;
      pRdData    <= '0;
      pRd        <= '0;
      pCtrl      <= '0;
      out_valid  <= 1'b0;
      out_alu    <= '0;
      out_mem    <= '0;
      out_branch <= '0;
      out_rd     <= '0;
      out_ctrl   <= '0;
      out_zero   <= 1'b0;
      out_neg    <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            pAlu    <= aluRes;
            pBranch <= in_se;
            pRd     <= in_rd;
            pCtrl   <= ctrlSel;
            if (in_ctrl[3]) begin
              // Read shares the edge with any write, so it sees the old word.
              pRdData <= mem[addr];
              state   <= MEMRD;
            end else if (goMul) begin
              cnt   <= CW'(MUL_LAT - 1);
              state <= MUL;
            end
          end
        end
        MEMRD: begin
          if (loadEn) state <= IDLE;
        end
        MUL: begin
          // The counter reaches 0 on the same edge the product loads, which
          // makes accept-to-valid exactly MUL_LAT cycles; the final step
          // holds at 1 while the buffer is still occupied.
          if (cnt > CW'(1)) begin
            cnt <= cnt - CW'(1);
          end else if (loadEn) begin
            cnt   <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (loadEn) begin
        out_valid  <= 1'b1;
        out_alu    <= ldAlu;
        out_mem    <= ldMem;
        out_branch <= ldBranch;
        out_rd     <= ldRd;
        out_ctrl   <= ldCtrl;
        out_zero   <= (ldAlu == '0);
        out_neg    <= ldAlu[DATA_W-1];
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
